// File: rtl/adc128s022_responder.sv
// SPI responder that stands in for an ADC128S022 8-channel 12-bit converter.
// It oversamples sclk/cs_n/copi on clk and decodes the 3-bit channel address
// from each 16-bit control word. It returns the sample for the address
// received in the previous frame.
// Optional build macro ADC128S022_RESPONDER_SYNC_EN adds 2-flop input
// synchronizers for hosts that are asynchronous to clk.
module adc128s022_responder #(
  parameter int unsigned Clock_Ratio_Min = 8
) (
  input  logic        clk,
  input  logic        async_rst,
  input  logic        clk_en,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        copi,
  input  logic [95:0] sample_data,
  output logic        cipo,
  output logic        cipo_oe,
  output logic        frame_done,
  output logic [2:0]  frame_channel,
  output logic        frame_abort
);

  // Input stage outputs, before the edge-detect registers.
  logic sclk_s, cs_n_s, copi_s;

`ifdef ADC128S022_RESPONDER_SYNC_EN
  logic [1:0] sclk_sync_q, cs_n_sync_q, copi_sync_q;

  // Two-flop synchronizers; cs_n resets to the deselected level.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      sclk_sync_q <= 2'b00;
      cs_n_sync_q <= 2'b11;
      copi_sync_q <= 2'b00;
    end else if (clk_en) begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_n_sync_q <= {cs_n_sync_q[0], cs_n};
      copi_sync_q <= {copi_sync_q[0], copi};
    end
  end

  assign sclk_s = sclk_sync_q[1];
  assign cs_n_s = cs_n_sync_q[1];
  assign copi_s = copi_sync_q[1];
`else
  assign sclk_s = sclk;
  assign cs_n_s = cs_n;
  assign copi_s = copi;
`endif

  logic sclk_q, sclk_prev_q, cs_n_q, cs_n_prev_q, copi_q;

  // Edge-detect registers: current and previous sampled levels.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      sclk_q      <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_n_q      <= 1'b1;
      cs_n_prev_q <= 1'b1;
      copi_q      <= 1'b0;
    end else if (clk_en) begin
      sclk_q      <= sclk_s;
      sclk_prev_q <= sclk_q;
      cs_n_q      <= cs_n_s;
      cs_n_prev_q <= cs_n_q;
      copi_q      <= copi_s;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q & sclk_prev_q;
  assign cs_fall   = ~cs_n_q & cs_n_prev_q;
  assign cs_rise   = cs_n_q & ~cs_n_prev_q;

  function automatic logic [11:0] chan_sample(input logic [95:0] data, input logic [2:0] ch);
    logic [11:0] res;
    res = 12'h000;
    unique case (ch)
      3'd0: res = data[11:0];
      3'd1: res = data[23:12];
      3'd2: res = data[35:24];
      3'd3: res = data[47:36];
      3'd4: res = data[59:48];
      3'd5: res = data[71:60];
      3'd6: res = data[83:72];
      3'd7: res = data[95:84];
    endcase
    return res;
  endfunction

  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_count_q, bit_count_d;
  logic [2:0]  cur_addr_q, cur_addr_d;
  logic [2:0]  next_addr_q, next_addr_d;
  logic        armed_q, armed_d;
  logic        oe_q, oe_d;
  logic        done_q, done_d;
  logic [2:0]  channel_q, channel_d;
  logic        abort_q, abort_d;

  // Frame engine next state; cs_n edges outrank same-cycle sclk edges.
  always_comb begin
    shift_d     = shift_q;
    bit_count_d = bit_count_q;
    cur_addr_d  = cur_addr_q;
    next_addr_d = next_addr_q;
    armed_d     = armed_q;
    oe_d        = oe_q;
    done_d      = 1'b0;
    channel_d   = channel_q;
    abort_d     = 1'b0;
    if (cs_n_q) begin
      // Deselected: drop any partial frame and address.
      oe_d        = 1'b0;
      bit_count_d = 4'd0;
      next_addr_d = 3'd0;
      armed_d     = 1'b0;
      if (cs_rise && (bit_count_q != 4'd0)) begin
        abort_d = 1'b1;
      end
    end else if (cs_fall) begin
      // next_addr is 0 here, so the first frame after select returns channel 0.
      shift_d    = {4'b0000, chan_sample(sample_data, next_addr_q)};
      cur_addr_d = next_addr_q;
      armed_d    = 1'b0;
      oe_d       = 1'b1;
    end else if (sclk_rise) begin
      armed_d     = 1'b1;
      bit_count_d = bit_count_q + 4'd1;
      case (bit_count_q)
        4'd2:    next_addr_d[2] = copi_q;
        4'd3:    next_addr_d[1] = copi_q;
        4'd4:    next_addr_d[0] = copi_q;
        default: ;
      endcase
      if (bit_count_q == 4'd15) begin
        done_d     = 1'b1;
        channel_d  = cur_addr_q;
        cur_addr_d = next_addr_q;
        shift_d    = {4'b0000, chan_sample(sample_data, next_addr_q)};
        armed_d    = 1'b0;
      end
    end else if (sclk_fall && armed_q) begin
      // Unarmed falls (CPOL=1 leading edge, post-reload edge) must not shift.
      shift_d = {shift_q[14:0], 1'b0};
    end
  end

  // Frame engine state register.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      shift_q     <= 16'h0000;
      bit_count_q <= 4'd0;
      cur_addr_q  <= 3'd0;
      next_addr_q <= 3'd0;
      armed_q     <= 1'b0;
      oe_q        <= 1'b0;
      done_q      <= 1'b0;
      channel_q   <= 3'd0;
      abort_q     <= 1'b0;
    end else if (clk_en) begin
      shift_q     <= shift_d;
      bit_count_q <= bit_count_d;
      cur_addr_q  <= cur_addr_d;
      next_addr_q <= next_addr_d;
      armed_q     <= armed_d;
      oe_q        <= oe_d;
      done_q      <= done_d;
      channel_q   <= channel_d;
      abort_q     <= abort_d;
    end
  end

  assign cipo          = shift_q[15];
  assign cipo_oe       = oe_q;
  assign frame_done    = done_q;
  assign frame_channel = channel_q;
  assign frame_abort   = abort_q;

`ifndef SYNTHESIS
  logic [31:0] period_cnt_q;

  // Qualified cycles since the last in-frame sclk rise (saturating).
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      period_cnt_q <= '1;
    end else if (clk_en) begin
      if (cs_n_q || cs_fall) begin
        period_cnt_q <= '1;
      end else if (sclk_rise) begin
        period_cnt_q <= '0;
      end else if (period_cnt_q != '1) begin
        period_cnt_q <= period_cnt_q + 32'd1;
      end
    end
  end

  sclk_ratio_check: assert property (@(posedge clk) disable iff (async_rst)
    (clk_en && sclk_rise && !cs_n_q) |-> (period_cnt_q >= Clock_Ratio_Min - 1));
`endif

endmodule

// File: tb/tb_adc128s022_responder.sv
// Self-checking bench for adc128s022_responder: a host model drives SPI
// frames, a reference model pushes expected frame results into a queue and a
// monitor pops and compares them on each frame_done/frame_abort pulse.
module tb_adc128s022_responder;

`ifdef ADC128S022_RESPONDER_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  localparam int H = 5;  // clk cycles per sclk half-period

  logic        clk = 1'b0;
  logic        async_rst;
  logic        clk_en;
  logic        sclk;
  logic        cs_n;
  logic        copi;
  logic [95:0] sample_data;
  logic        cipo;
  logic        cipo_oe;
  logic        frame_done;
  logic [2:0]  frame_channel;
  logic        frame_abort;

  always #5 clk = ~clk;

  adc128s022_responder #(
    .Clock_Ratio_Min(8)
  ) dut (
    .clk          (clk),
    .async_rst    (async_rst),
    .clk_en       (clk_en),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .copi         (copi),
    .sample_data  (sample_data),
    .cipo         (cipo),
    .cipo_oe      (cipo_oe),
    .frame_done   (frame_done),
    .frame_channel(frame_channel),
    .frame_abort  (frame_abort)
  );

  typedef struct {
    bit          is_abort;
    logic [2:0]  chan;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [11:0] samples[8];
  logic [2:0]  model_next;  // channel the next completed frame returns
  logic [15:0] host_word;
  bit          cpol_cur;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_samples();
    for (int i = 0; i < 8; i++) sample_data[i*12 +: 12] = samples[i];
  endtask

  task automatic select(input bit cpol, input bit chk);
    cpol_cur = cpol;
    sclk = cpol;
    wait_clks(H);
    cs_n = 1'b0;
    model_next = 3'd0;
    if (chk) begin
      wait_clks(S + 1);
      check("oe_before_latency", 32'(cipo_oe), 32'd0);
      wait_clks(1);
      check("oe_after_select", 32'(cipo_oe), 32'd1);
    end
    wait_clks(H);
  endtask

  task automatic deselect();
    sclk = cpol_cur;
    wait_clks(H);
    cs_n = 1'b1;
    wait_clks(H);
    check("oe_after_deselect", 32'(cipo_oe), 32'd0);
  endtask

  // One host frame. stop_at=0: full 16 bits; otherwise stop after stop_at
  // rising edges by raising cs_n (rst_stop=0) or asserting reset (rst_stop=1).
  task automatic do_frame(input logic [2:0] addr, input int stop_at, input bit rst_stop,
                          input int chg_at, input logic [2:0] chg_ch,
                          input logic [11:0] chg_val);
    logic [15:0] din;
    logic [15:0] word;
    din = 16'($urandom);
    din[13:11] = addr;
    if (stop_at == 0) exp_q.push_back('{1'b0, model_next, {4'h0, samples[model_next]}});
    else if (!rst_stop) exp_q.push_back('{1'b1, 3'd0, 16'h0000});
    word = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      sclk = 1'b0;
      copi = din[15-k];
      wait_clks(H);
      sclk = 1'b1;
      word = {word[14:0], cipo};
      if (k == 15) host_word = word;
      if (k == chg_at) begin
        samples[chg_ch] = chg_val;
        apply_samples();
      end
      if (stop_at != 0 && k + 1 == stop_at) begin
        if (rst_stop) begin
          #1;
          async_rst = 1'b1;
          #1;
          check("rst_cipo", 32'(cipo), 32'd0);
          check("rst_cipo_oe", 32'(cipo_oe), 32'd0);
          check("rst_frame_done", 32'(frame_done), 32'd0);
          check("rst_frame_channel", 32'(frame_channel), 32'd0);
          check("rst_frame_abort", 32'(frame_abort), 32'd0);
          cs_n = 1'b1;
          sclk = 1'b0;
          copi = 1'b0;
          wait_clks(3);
          async_rst = 1'b0;
          wait_clks(H);
        end else begin
          wait_clks(H);
          cs_n = 1'b1;
          wait_clks(H);
          sclk = cpol_cur;
          wait_clks(H);
          check("oe_after_abort", 32'(cipo_oe), 32'd0);
        end
        return;
      end
      wait_clks(H);
    end
    model_next = addr;
  endtask

  initial begin
    async_rst = 1'b1;
    clk_en = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    copi = 1'b0;
    for (int i = 0; i < 8; i++) samples[i] = 12'($urandom);
    samples[0] = 12'hA5C;
    samples[5] = 12'h123;
    samples[3] = 12'hFFF;
    apply_samples();
    model_next = 3'd0;
    host_word = 16'h0000;
    cpol_cur = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!async_rst && (frame_done || frame_abort)) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got done=%0b abort=%0b, required no pulse",
                     frame_done, frame_abort);
          end else begin
            mon_e = exp_q.pop_front();
            check("event_kind", 32'({frame_abort, frame_done}), mon_e.is_abort ? 32'd2 : 32'd1);
            if (!mon_e.is_abort) begin
              check("frame_channel", 32'(frame_channel), 32'(mon_e.chan));
              check("dout_word", 32'(host_word), 32'(mon_e.data));
            end
          end
        end
      end
    join_none

    // Reset values.
    wait_clks(3);
    check("reset_cipo", 32'(cipo), 32'd0);
    check("reset_cipo_oe", 32'(cipo_oe), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_frame_channel", 32'(frame_channel), 32'd0);
    check("reset_frame_abort", 32'(frame_abort), 32'd0);
    async_rst = 1'b0;
    wait_clks(4);

    // clk_en low holds everything, so a select pulse is never seen.
    clk_en = 1'b0;
    cs_n = 1'b0;
    wait_clks(6);
    check("hold_oe_while_disabled", 32'(cipo_oe), 32'd0);
    cs_n = 1'b1;
    wait_clks(6);
    clk_en = 1'b1;
    wait_clks(6);
    check("hold_oe_after_enable", 32'(cipo_oe), 32'd0);

    // Select, then pipelined addresses 5 and 3: channels 0, 5, 3.
    select(1'b0, 1'b1);
    do_frame(3'd5, 0, 1'b0, -1, 3'd0, 12'h000);
    do_frame(3'd3, 0, 1'b0, -1, 3'd0, 12'h000);
    do_frame(3'd0, 0, 1'b0, -1, 3'd0, 12'h000);
    deselect();

    // ch5 read with sclk idle high, then idle low.
    select(1'b1, 1'b0);
    do_frame(3'd5, 0, 1'b0, -1, 3'd0, 12'h000);
    do_frame(3'd0, 0, 1'b0, -1, 3'd0, 12'h000);
    deselect();
    select(1'b0, 1'b0);
    do_frame(3'd5, 0, 1'b0, -1, 3'd0, 12'h000);
    do_frame(3'd0, 0, 1'b0, -1, 3'd0, 12'h000);
    deselect();

    // Abort after 7 rising edges; the next select returns channel 0.
    select(1'b0, 1'b0);
    do_frame(3'd5, 0, 1'b0, -1, 3'd0, 12'h000);
    do_frame(3'd5, 7, 1'b0, -1, 3'd0, 12'h000);
    select(1'b0, 1'b0);
    do_frame(3'd2, 0, 1'b0, -1, 3'd0, 12'h000);
    deselect();

    // ch0 changes at bit 6: the frame in flight keeps the old value.
    samples[0] = 12'h001;
    apply_samples();
    select(1'b0, 1'b0);
    do_frame(3'd0, 0, 1'b0, 6, 3'd0, 12'h800);
    do_frame(3'd0, 0, 1'b0, -1, 3'd0, 12'h000);
    deselect();

    // Reset at bit 9 of a frame: silent drop, outputs clear immediately.
    select(1'b1, 1'b0);
    do_frame(3'd6, 0, 1'b0, -1, 3'd0, 12'h000);
    do_frame(3'd1, 0, 1'b0, -1, 3'd0, 12'h000);
    do_frame(3'd4, 9, 1'b1, -1, 3'd0, 12'h000);
    check("queue_empty_after_reset", 32'(exp_q.size()), 32'd0);

    // Randomized bursts.
    for (int b = 0; b < 30; b++) begin
      int   n;
      bit   aborted;
      int   chg;
      for (int i = 0; i < 8; i++) samples[i] = 12'($urandom);
      apply_samples();
      select(1'($urandom_range(0, 1)), 1'b0);
      n = $urandom_range(1, 4);
      aborted = 1'b0;
      for (int f = 0; f < n; f++) begin
        chg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
        if (f == n - 1 && $urandom_range(0, 4) == 0) begin
          do_frame(3'($urandom), int'($urandom_range(1, 15)), 1'b0, chg, 3'($urandom),
                   12'($urandom));
          aborted = 1'b1;
        end else begin
          do_frame(3'($urandom), 0, 1'b0, chg, 3'($urandom), 12'($urandom));
        end
      end
      if (!aborted) deselect();
    end

    wait_clks(10);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
